// File: rtl/barrel_shifter_16.sv
// 16-bit logical barrel shifter: four cascaded 2:1 mux stages (by 1, 2, 4, 8)
// feeding a single registered output. Direction 1 = left, 0 = right.
module barrel_shifter_16 (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] i,
   input  logic        s0,
   input  logic        s1,
   input  logic        s2,
   input  logic        s3,
   input  logic        shift_sel,
   output logic [15:0] o
);

   logic [15:0] stage_1;
   logic [15:0] stage_2;
   logic [15:0] stage_4;
   logic [15:0] stage_8;

   // Each stage either passes its input or shifts it by its weight, zero-filling
   // the vacated end; bits pushed past the edge are dropped (not a rotate).
   always_comb begin
      stage_1 = i;
      if (s0) begin
         stage_1 = shift_sel ? {i[14:0], 1'b0} : {1'b0, i[15:1]};
      end

      stage_2 = stage_1;
      if (s1) begin
         stage_2 = shift_sel ? {stage_1[13:0], 2'b00} : {2'b00, stage_1[15:2]};
      end

      stage_4 = stage_2;
      if (s2) begin
         stage_4 = shift_sel ? {stage_2[11:0], 4'h0} : {4'h0, stage_2[15:4]};
      end

      stage_8 = stage_4;
      if (s3) begin
         stage_8 = shift_sel ? {stage_4[7:0], 8'h00} : {8'h00, stage_4[15:8]};
      end
   end

   // Only state in the block; reset takes priority over the data path.
   always_ff @(posedge clk) begin
      if (rst) begin
         o <= 16'h0000;
      end else begin
         o <= stage_8;
      end
   end

endmodule

// File: tb/tb_barrel_shifter_16.sv
// Directed bench for barrel_shifter_16: a driver queues the expected result of
// each edge, and a monitor pops and compares one entry after every rising edge.
module tb_barrel_shifter_16;

   logic        clk;
   logic        rst;
   logic [15:0] i;
   logic        s0;
   logic        s1;
   logic        s2;
   logic        s3;
   logic        shift_sel;
   logic [15:0] o;

   logic [15:0] exp_q[$];
   string       name_q[$];
   int          n_vec;
   int          n_err;

   barrel_shifter_16 dut (
      .clk       (clk),
      .rst       (rst),
      .i         (i),
      .s0        (s0),
      .s1        (s1),
      .s2        (s2),
      .s3        (s3),
      .shift_sel (shift_sel),
      .o         (o)
   );

   // clock / initial values
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      rst       = 1'b1;
      i         = 16'h0000;
      {s3, s2, s1, s0} = 4'h0;
      shift_sel = 1'b0;
   end

   // reference model: plain shift operators, independent of the mux structure
   function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic dir,
                                             input logic [3:0] n);
      logic [31:0] wide;
      wide = {16'h0000, d};
      if (dir) ref_shift = 16'(wide << n);
      else     ref_shift = 16'(wide >> n);
   endfunction

   // driver: one call == one rising edge; inputs change at the falling edge
   task automatic apply(input logic r, input logic [15:0] d, input logic dir,
                        input logic [3:0] n, input logic [15:0] e, input string nm);
      @(negedge clk);
      rst       = r;
      i         = d;
      shift_sel = dir;
      {s3, s2, s1, s0} = n;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge clk);
   endtask

   // monitor: the result of edge k is on o shortly after edge k
   always @(posedge clk) begin
      logic [15:0] e;
      string       nm;
      #1;
      if (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         n_vec++;
         if (o !== e) begin
            n_err++;
            $display("FAIL %s: o=%h expected=%h", nm, o, e);
         end
      end
   end

   initial begin
      n_vec = 0;
      n_err = 0;

      // reset with all-ones data, left, n=0
      apply(1'b1, 16'hFFFF, 1'b1, 4'd0, 16'h0000, "reset_edge0");
      apply(1'b1, 16'hFFFF, 1'b1, 4'd0, 16'h0000, "reset_edge1");
      apply(1'b0, 16'hFFFF, 1'b1, 4'd0, 16'hFFFF, "reset_release");

      // left by 8
      apply(1'b0, 16'hA861, 1'b1, 4'd8, 16'h6100, "left8_a861");
      apply(1'b0, 16'hFFFF, 1'b1, 4'd8, 16'hFF00, "left8_ffff");

      // left by 3
      apply(1'b0, 16'h0000, 1'b1, 4'd3, 16'h0000, "left3_0000");
      apply(1'b0, 16'hCE39, 1'b1, 4'd3, 16'h71C8, "left3_ce39");

      // right by 15
      apply(1'b0, 16'h0001, 1'b0, 4'd15, 16'h0000, "right15_0001");
      apply(1'b0, 16'h8000, 1'b0, 4'd15, 16'h0001, "right15_8000");

      // back-to-back, inputs change every cycle
      apply(1'b0, 16'hD70F, 1'b1, 4'd12, 16'hF000, "b2b_left12_d70f");
      apply(1'b0, 16'h1234, 1'b0, 4'd4,  16'h0123, "b2b_right4_1234");
      apply(1'b0, 16'h8001, 1'b1, 4'd1,  16'h0002, "b2b_left1_8001");
      apply(1'b0, 16'hF0F0, 1'b0, 4'd1,  16'h7878, "b2b_right1_f0f0");
      apply(1'b0, 16'h00FF, 1'b1, 4'd0,  16'h00FF, "b2b_pass_left");
      apply(1'b0, 16'h00FF, 1'b0, 4'd0,  16'h00FF, "b2b_pass_right");

      // sweep of direction x amount, with a reset injected mid-sweep
      for (int dir = 0; dir < 2; dir++) begin
         for (int n = 0; n < 16; n++) begin
            if (dir == 1 && n == 6) begin
               apply(1'b1, 16'hA5C3, 1'b1, 4'd6, 16'h0000, "sweep_mid_reset");
            end
            apply(1'b0, 16'hA5C3, dir[0], n[3:0],
                  ref_shift(16'hA5C3, dir[0], n[3:0]),
                  $sformatf("sweep_dir%0d_n%0d", dir, n));
         end
      end

      // let the monitor consume the last entry, then confirm nothing was left
      repeat (3) @(posedge clk);
      #2;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: pending=%0d expected=0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/barrel_shifter_16.md
# barrel_shifter_16

16-bit bidirectional logical barrel shifter with a registered output, used as the shift unit of the datapath. A 4-bit shift amount from four discrete select lines and a direction select pick the result. Data is shifted through four cascaded 2:1 mux stages and captured in an output register on every clock edge.

## Interface
Parameters: none. Width is fixed at 16 bits and shift amount at 4 bits.

- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  reset; synchronous, active-high (one clock; reset is synchronous and active-high)
- i  input  16  data to be shifted
- s0  input  1  shift-amount bit 0 (weight 1)
- s1  input  1  shift-amount bit 1 (weight 2)
- s2  input  1  shift-amount bit 2 (weight 4)
- s3  input  1  shift-amount bit 3 (weight 8)
- shift_sel  input  1  direction: 1 = shift left (toward MSB), 0 = shift right (toward LSB)
- o  output  16  registered shift result

## Operation
- Shift amount n = {s3,s2,s1,s0}, unsigned, range 0..15.
- shift_sel=1: result = (i << n) truncated to 16 bits. Vacated LSBs are filled with 0.
- shift_sel=0: result = i >> n, logical. Vacated MSBs are filled with 0 and there is no sign extension.
- Bits shifted past either end are discarded. This is not a rotate.
- n=0 passes i through unchanged in either direction.
- Structure: four mux stages in order s0 (by 1), s1 (by 2), s2 (by 4), s3 (by 8).
  - Each stage either passes its input or shifts it by its weight in the direction given by shift_sel.
  - Each stage output feeds the next; the stage-4 output feeds the o register.
- The stages are purely combinational. The only state is the 16-bit o register.
- There is no enable and no valid/ready handshake. A new result is registered every cycle.

## Timing
- Latency is 1 cycle. Inputs (i, s0..s3, shift_sel) present before rising edge k appear on o after edge k.
- Throughput is one result per cycle. Inputs may change every cycle.
- Reset: rst=1 sampled at a rising edge forces o=16'h0000, and reset overrides the data path.
- Reset value of o is 16'h0000.
- o holds 16'h0000 for every edge at which rst=1. The first edge with rst=0 captures the current inputs.
- o is undefined before the first reset edge. Benches must reset first.
- Reset mid-stream: the in-flight result is discarded. There is no recovery state.
- Inputs changing between edges have no effect on o until the next edge. o never glitches.

## Test plan
- Reset: drive i=16'hFFFF, shift_sel=1, n=0, assert rst for 2 edges. Required: o=16'h0000 each cycle. Release rst, then o=16'hFFFF one edge later.
- Left by 8:
  - i=16'hA861, shift_sel=1, s3=1, s2..s0=0 -> o=16'h6100.
  - i=16'hFFFF, same selects -> o=16'hFF00.
- Left by 3:
  - i=16'h0000, shift_sel=1, s1=s0=1 -> o=16'h0000.
  - i=16'hCE39, same selects -> o=16'h71C8.
- Right by 15:
  - i=16'h0001, shift_sel=0, all s=1 -> o=16'h0000.
  - i=16'h8000, same selects -> o=16'h0001.
- Left by 12 with back-to-back cycles: i=16'hD70F, shift_sel=1, s3=s2=1 -> o=16'hF000. Change inputs every cycle and check each result lands exactly one edge later.
- Exhaustive sweep: i=16'hA5C3, all 32 combinations of shift_sel and n against a reference model. Then assert rst mid-sweep and check o=16'h0000 on that edge.
